// File: rtl/riscv_pkg.sv
// riscv_pkg: fetch FSM states, NOP encoding and base opcodes shared by the front end.
package riscv_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HOLD} if_state_e;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry holding register for a fetched word that arrives while decode is stalled.
module if_skid_buf
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  input  logic [31:0] i_pc,
  output logic [31:0] o_data,
  output logic [31:0] o_pc,
  output logic        o_valid
);
  logic [31:0] r_data, r_pc;
  logic        r_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= NOP_INST;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_load) begin
        r_data <= i_data;
        r_pc   <= i_pc;
      end
      r_valid <= i_clear ? 1'b0 : i_load ? 1'b1 : i_unload ? 1'b0 : r_valid;
    end
  end
  assign o_data  = r_data;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit with IF/ID register, skid entry and redirect.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);
  if_state_e   r_state, w_state_n;
  logic [31:0] r_pc, w_pc_n, r_inst, w_inst_n, r_if_pc, w_if_pc_n;
  logic        r_valid, w_valid_n;
  logic        w_skid_load, w_skid_unload, w_skid_clear, w_skid_valid;
  logic [31:0] w_skid_data, w_skid_pc;
  logic [31:0] w_pc_inc;

  assign w_pc_inc = r_pc + 32'd4;

  always_comb begin
    w_state_n     = r_state;
    w_pc_n        = r_pc;
    w_inst_n      = r_inst;
    w_if_pc_n     = r_if_pc;
    w_valid_n     = r_valid & id_stall;
    w_skid_load   = 1'b0;
    w_skid_unload = 1'b0;
    w_skid_clear  = 1'b0;
    if (branch_taken) begin
      // a response still in flight must be swallowed in DRAIN before the new request goes out
      w_pc_n       = word_align(branch_target);
      w_valid_n    = 1'b0;
      w_skid_clear = 1'b1;
      w_state_n    = (r_state == REQ) ? (imem_ready ? DRAIN : REQ)
                   : ((r_state == WAIT || r_state == DRAIN) && !imem_rvalid) ? DRAIN : REQ;
    end else begin
      case (r_state)
        IDLE:    w_state_n = REQ;
        REQ:     w_state_n = imem_ready ? WAIT : REQ;
        WAIT: begin
          if (imem_rvalid) begin
            w_pc_n = w_pc_inc;
            if (id_stall && r_valid) begin
              w_skid_load = 1'b1;
              w_state_n   = HOLD;
            end else begin
              w_inst_n  = imem_rdata;
              w_if_pc_n = r_pc;
              w_valid_n = 1'b1;
              w_state_n = REQ;
            end
          end
        end
        DRAIN:   w_state_n = imem_rvalid ? REQ : DRAIN;
        HOLD: begin
          if (!id_stall) begin
            w_skid_unload = 1'b1;
            w_inst_n      = w_skid_data;
            w_if_pc_n     = w_skid_pc;
            w_valid_n     = w_skid_valid;
            w_state_n     = REQ;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_inst  <= NOP_INST;
      r_if_pc <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_inst  <= w_inst_n;
      r_if_pc <= w_if_pc_n;
      r_valid <= w_valid_n;
    end
  end

  if_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (w_skid_clear),
    .i_data   (imem_rdata),
    .i_pc     (r_pc),
    .o_data   (w_skid_data),
    .o_pc     (w_skid_pc),
    .o_valid  (w_skid_valid)
  );

  assign imem_req  = (r_state == REQ);
  assign imem_addr = r_pc;
  assign if_valid  = r_valid;
  assign if_inst   = r_valid ? r_inst : NOP_INST;
  assign if_pc     = r_if_pc;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus a randomized run against a program-order fetch model.
module tb_instr_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        rst_n, imem_ready, imem_rvalid, branch_taken, id_stall;
  logic [31:0] imem_rdata, branch_target;
  logic        imem_req, if_valid, imem_req2, if_valid2;
  logic [31:0] imem_addr, if_inst, if_pc, imem_addr2, if_inst2, if_pc2;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target), .id_stall(id_stall),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target), .id_stall(id_stall),
    .if_valid(if_valid2), .if_inst(if_inst2), .if_pc(if_pc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] d);
    imem_ready = 1'b1;
    tick;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    tick;
    imem_rvalid = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  logic        pending, p_branch, p_valid, p_stall, p_req, p_ready, p_rvalid;
  logic [31:0] paddr, exp_pc, p_inst, p_pc, p_addr, p_target;
  int          cnt;

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    branch_taken = 1'b0; branch_target = '0; id_stall = 1'b0;
    tick;
    tick;
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk1("rst_valid", if_valid, 1'b0);
    chk("rst_inst", if_inst, NOP);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_addr2", imem_addr2, 32'hFFFF_FFFC);
    rst_n = 1'b1;
    tick;
    chk1("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);
    fetch(32'h0050_0093);
    chk1("f1_valid", if_valid, 1'b1);
    chk("f1_pc", if_pc, 32'h0);
    chk("f1_inst", if_inst, 32'h0050_0093);
    chk("f1_next_addr", imem_addr, 32'h4);
    chk("wrap_pc2", if_pc2, 32'hFFFF_FFFC);
    chk("wrap_addr2", imem_addr2, 32'h0);
    fetch(32'h0010_0093);
    chk("f2_pc", if_pc, 32'h4);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk1("notready_req", imem_req, 1'b1);
      chk("notready_addr", imem_addr, 32'h8);
      chk1("idle_valid", if_valid, 1'b0);
      chk("idle_nop", if_inst, NOP);
    end
    fetch(32'h0000_00B3);
    chk("f3_pc", if_pc, 32'h8);
    id_stall = 1'b1;
    imem_ready = 1'b1;
    tick;
    imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0113;
    tick;
    imem_rvalid = 1'b0;
    chk1("hold_valid", if_valid, 1'b1);
    chk("hold_inst", if_inst, 32'h0000_00B3);
    chk("hold_pc", if_pc, 32'h8);
    chk1("hold_req", imem_req, 1'b0);
    tick;
    chk("hold2_inst", if_inst, 32'h0000_00B3);
    chk1("hold2_req", imem_req, 1'b0);
    id_stall = 1'b0;
    tick;
    chk("skid_inst", if_inst, 32'h0000_0113);
    chk("skid_pc", if_pc, 32'hC);
    chk1("skid_valid", if_valid, 1'b1);
    chk("skid_addr", imem_addr, 32'h10);
    imem_ready = 1'b1;
    tick;
    imem_ready = 1'b0;
    chk1("wait_req", imem_req, 1'b0);
    branch_taken = 1'b1; branch_target = 32'h0000_0102;
    tick;
    branch_taken = 1'b0;
    chk1("br_valid", if_valid, 1'b0);
    chk("br_nop", if_inst, NOP);
    chk1("drain_req", imem_req, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick;
    imem_rvalid = 1'b0;
    chk1("drop_valid", if_valid, 1'b0);
    chk1("br_req", imem_req, 1'b1);
    chk("br_addr", imem_addr, 32'h0000_0100);
    branch_taken = 1'b1; branch_target = 32'h0000_0203;
    tick;
    branch_taken = 1'b0;
    chk1("retarget_req", imem_req, 1'b1);
    chk("retarget_addr", imem_addr, 32'h0000_0200);
    imem_ready = 1'b1;
    tick;
    imem_ready = 1'b0;
    rst_n = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    #1;
    chk1("arst_req", imem_req, 1'b0);
    chk("arst_addr", imem_addr, 32'h0);
    chk1("arst_valid", if_valid, 1'b0);
    chk("arst_inst", if_inst, NOP);
    chk("arst_pc", if_pc, 32'h0);
    tick;
    rst_n = 1'b1;
    tick;
    imem_rvalid = 1'b0;
    chk1("late_valid", if_valid, 1'b0);
    chk1("late_req", imem_req, 1'b1);
    chk("late_addr", imem_addr, 32'h0);
    fetch(32'h0020_0093);
    chk1("post_valid", if_valid, 1'b1);
    chk("post_pc", if_pc, 32'h0);
    chk("post_inst", if_inst, 32'h0020_0093);

    // randomized phase: expectations come from program order and the memory's contents
    rst_n = 1'b0; id_stall = 1'b0; imem_ready = 1'b0; branch_taken = 1'b0;
    tick;
    rst_n = 1'b1;
    exp_pc = 32'h0; pending = 1'b0; paddr = '0; cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      id_stall      = ($urandom_range(0, 3) == 0);
      imem_ready    = ($urandom_range(0, 2) != 0);
      branch_taken  = ($urandom_range(0, 19) == 0);
      branch_target = $urandom;
      imem_rvalid   = pending && (cnt == 0);
      imem_rdata    = imem_rvalid ? mem_word(paddr) : $urandom;
      p_branch = branch_taken; p_valid = if_valid; p_stall = id_stall;
      p_req = imem_req; p_ready = imem_ready; p_rvalid = imem_rvalid;
      p_inst = if_inst; p_pc = if_pc; p_addr = imem_addr; p_target = branch_target;
      tick;
      if (p_rvalid) pending = 1'b0;
      else if (pending) cnt--;
      if (p_req && p_ready) begin
        pending = 1'b1;
        paddr   = p_addr;
        cnt     = int'($urandom_range(0, 2));
      end
      if (p_branch) begin
        chk1("r_br_valid", if_valid, 1'b0);
        exp_pc = p_target & ~32'h3;
      end else if (p_valid && p_stall) begin
        chk1("r_stall_valid", if_valid, 1'b1);
        chk("r_stall_inst", if_inst, p_inst);
        chk("r_stall_pc", if_pc, p_pc);
      end else if (if_valid) begin
        chk("r_order_pc", if_pc, exp_pc);
        chk("r_inst", if_inst, mem_word(if_pc));
        exp_pc = exp_pc + 32'd4;
      end
      if (!if_valid) chk("r_nop", if_inst, NOP);
      if (p_req && !p_ready && !p_branch) begin
        chk1("r_req_stable", imem_req, 1'b1);
        chk("r_addr_stable", imem_addr, p_addr);
      end
      chk1("r_one_outstanding", imem_req && pending, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
